// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      SUB,
      SUB_ACK,
      WDATA,
      WDATA_ACK,
      EXTRA,
      RDATA,
      RDATA_ACK,
      WAIT_STOP
   } sccb_state_e;

   localparam logic [7:0] BANK_SEL_ADDR = 8'hFF;
   localparam logic       SCCB_WRITE    = 1'b0;
   localparam logic       SCCB_READ     = 1'b1;

   function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
      return {cur[6:0], b};
   endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SCL/SDA and produces one-cycle edge, START and STOP pulses.
module sccb_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;
   logic                   sda_rise;
   logic                   sda_fall;

   // Idle bus level is high, so flops reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
         sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign sda_o      = sda_s;
   assign scl_rise_o = scl_s & ~scl_prev_q;
   assign scl_fall_o = ~scl_s & scl_prev_q;
   assign sda_rise   = sda_s & ~sda_prev_q;
   assign sda_fall   = ~sda_s & sda_prev_q;
   assign start_o    = sda_fall & scl_s & scl_prev_q;
   assign stop_o     = sda_rise & scl_s & scl_prev_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB device-side responder: decodes write/read transactions and drives
// the open-drain SDA through sda_oe.
//
// state     | meaning
// IDLE      | bus idle, waiting for START
// ADDR      | shifting device address byte
// ADDR_ACK  | acknowledging our address
// SUB       | shifting sub-address
// SUB_ACK   | acknowledging sub-address
// WDATA     | shifting write data byte
// WDATA_ACK | acknowledging write data
// EXTRA     | surplus bytes, ignored and not acknowledged
// RDATA     | driving a read byte
// RDATA_ACK | releasing SDA, sampling master ACK/NACK
// WAIT_STOP | not addressed or read ended, waiting for START/STOP
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h30,
   parameter int         SYNC_STAGES = 2,
   parameter int         HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   input  logic [7:0] reg_rdata,
   output logic       bank,
   output logic       busy
);

   localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   sccb_state_e       state_q;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic              rw_q;
   logic              ack_rise_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic              hold_val_q;
   logic              hold_act_q;

   logic              sda_s;
   logic              scl_rise;
   logic              scl_fall;
   logic              start_p;
   logic              stop_p;
   logic [7:0]        byte_d;
   logic              last_bit;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i      (clk),
      .reset_i    (reset),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_p),
      .stop_o     (stop_p)
   );

   assign byte_d   = shift_in(shift_q, sda_s);
   assign last_bit = (bit_cnt_q == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rw_q       <= SCCB_WRITE;
         ack_rise_q <= 1'b0;
         hold_cnt_q <= '0;
         hold_val_q <= 1'b0;
         hold_act_q <= 1'b0;
         sda_oe     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_wr     <= 1'b0;
         bank       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         reg_wr <= 1'b0;

         // SDA only changes HOLD_CYCLES after the SCL fall that scheduled it.
         if (hold_act_q) begin
            if (hold_cnt_q == '0) begin
               sda_oe     <= hold_val_q;
               hold_act_q <= 1'b0;
            end else begin
               hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end
         end

         if (start_p) begin
            state_q    <= ADDR;
            bit_cnt_q  <= '0;
            busy       <= 1'b1;
            sda_oe     <= 1'b0;
            hold_act_q <= 1'b0;
         end else if (stop_p) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            sda_oe     <= 1'b0;
            hold_act_q <= 1'b0;
         end else if (scl_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shift_q   <= byte_d;
            case (state_q)
               ADDR: if (last_bit) begin
                  ack_rise_q <= 1'b0;
                  if (byte_d[7:1] == DEV_ADDR) begin
                     state_q <= ADDR_ACK;
                     rw_q    <= byte_d[0];
                  end else begin
                     state_q <= WAIT_STOP;
                  end
               end
               SUB: if (last_bit) begin
                  reg_addr   <= byte_d;
                  state_q    <= SUB_ACK;
                  ack_rise_q <= 1'b0;
               end
               WDATA: if (last_bit) begin
                  reg_wdata  <= byte_d;
                  reg_wr     <= 1'b1;
                  if (reg_addr == BANK_SEL_ADDR) bank <= byte_d[0];
                  state_q    <= WDATA_ACK;
                  ack_rise_q <= 1'b0;
               end
               ADDR_ACK, SUB_ACK, WDATA_ACK: ack_rise_q <= 1'b1;
               RDATA: begin
                  shift_q <= {shift_q[6:0], 1'b0};
                  if (last_bit) state_q <= RDATA_ACK;
               end
               RDATA_ACK: begin
                  if (sda_s) begin
                     state_q <= WAIT_STOP;
                  end else begin
                     shift_q   <= reg_rdata;
                     bit_cnt_q <= '0;
                     state_q   <= RDATA;
                  end
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            hold_act_q <= 1'b1;
            hold_cnt_q <= HOLD_LOAD;
            hold_val_q <= 1'b0;
            case (state_q)
               ADDR_ACK: begin
                  if (!ack_rise_q) begin
                     hold_val_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= '0;
                     if (rw_q == SCCB_READ) begin
                        state_q    <= RDATA;
                        shift_q    <= reg_rdata;
                        hold_val_q <= ~reg_rdata[7];
                     end else begin
                        state_q <= SUB;
                     end
                  end
               end
               SUB_ACK: begin
                  if (!ack_rise_q) begin
                     hold_val_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= '0;
                     state_q   <= WDATA;
                  end
               end
               WDATA_ACK: begin
                  if (!ack_rise_q) begin
                     hold_val_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= '0;
                     state_q   <= EXTRA;
                  end
               end
               RDATA: hold_val_q <= ~shift_q[7];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB master, register-file model and
// a write-strobe scoreboard.
module tb_sccb_target;

   localparam int         HALF   = 20;
   localparam logic [7:0] RD_KEY = 8'hAF;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
      logic       b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_m;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic [7:0] reg_rdata;
   logic       bank;
   logic       busy;

   int   vectors     = 0;
   int   miscompares = 0;
   int   oe_cnt      = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   assign sda_line  = sda_m & ~sda_oe;
   assign reg_rdata = reg_addr ^ RD_KEY;

   sccb_target #(.DEV_ADDR(7'h30), .SYNC_STAGES(2), .HOLD_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rdata (reg_rdata),
      .bank      (bank),
      .busy      (busy)
   );

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic scoreboard_mon();
      exp_t e;
      forever begin
         @(negedge clk);
         if (sda_oe) oe_cnt++;
         if (reg_wr) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_wr got addr=%02h data=%02h bank=%0b, none expected",
                        reg_addr, reg_wdata, bank);
            end else begin
               e = exp_q.pop_front();
               if ({reg_addr, reg_wdata, bank} !== {e.a, e.d, e.b}) begin
                  miscompares++;
                  $display("FAIL wr_strobe got addr=%02h data=%02h bank=%0b, want addr=%02h data=%02h bank=%0b",
                           reg_addr, reg_wdata, bank, e.a, e.d, e.b);
               end
            end
         end
      end
   endtask

   task automatic bus_start();
      if (!scl_m) begin
         wait_clk(5);
         sda_m = 1'b1;
         wait_clk(HALF - 5);
         scl_m = 1'b1;
         wait_clk(HALF);
      end
      sda_m = 1'b0;
      wait_clk(HALF);
      scl_m = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(5);
      sda_m = 1'b0;
      wait_clk(HALF - 5);
      scl_m = 1'b1;
      wait_clk(HALF);
      sda_m = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         wait_clk(5);
         sda_m = b[7-i];
         wait_clk(HALF - 5);
         scl_m = 1'b1;
         wait_clk(HALF);
         scl_m = 1'b0;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      wait_clk(5);
      sda_m = 1'b1;
      wait_clk(HALF - 5);
      scl_m = 1'b1;
      wait_clk(HALF / 2);
      ack = sda_line;
      wait_clk(HALF / 2);
      scl_m = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic mack);
      for (int i = 0; i < 8; i++) begin
         wait_clk(5);
         sda_m = 1'b1;
         wait_clk(HALF - 5);
         scl_m = 1'b1;
         wait_clk(HALF / 2);
         b[7-i] = sda_line;
         wait_clk(HALF / 2);
         scl_m = 1'b0;
      end
      wait_clk(5);
      sda_m = mack;
      wait_clk(HALF - 5);
      scl_m = 1'b1;
      wait_clk(HALF);
      scl_m = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(5);
      @(negedge clk);
      vectors++;
      if ({sda_oe, reg_addr, reg_wdata, reg_wr, bank, busy} !== 20'h0) begin
         miscompares++;
         $display("FAIL reset_values got oe=%0b addr=%02h wdata=%02h wr=%0b bank=%0b busy=%0b, want all 0",
                  sda_oe, reg_addr, reg_wdata, reg_wr, bank, busy);
      end
      reset = 1'b0;
      wait_clk(10);
   endtask

   task automatic test_write_basic();
      logic ack;
      logic [7:0] bytes [3];
      bytes[0] = 8'h60; bytes[1] = 8'h12; bytes[2] = 8'h80;
      exp_q.push_back('{a: 8'h12, d: 8'h80, b: 1'b0});
      bus_start();
      for (int i = 0; i < 3; i++) begin
         write_byte(bytes[i], ack);
         vectors++;
         if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL write_ack byte%0d got sda=%0b, want 0", i, ack);
         end
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_mid got %0b, want 1", busy);
      end
      bus_stop();
      vectors++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL write_done got busy=%0b pending=%0d, want busy=0 pending=0", busy, exp_q.size());
      end
   endtask

   task automatic test_addr_mismatch();
      logic ack;
      logic [7:0] bytes [3];
      int oe_before;
      bytes[0] = 8'h42; bytes[1] = 8'h12; bytes[2] = 8'h80;
      oe_before = oe_cnt;
      bus_start();
      for (int i = 0; i < 3; i++) begin
         write_byte(bytes[i], ack);
         vectors++;
         if (ack !== 1'b1) begin
            miscompares++;
            $display("FAIL mismatch_nack byte%0d got sda=%0b, want 1", i, ack);
         end
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mismatch_busy got %0b, want 1", busy);
      end
      bus_stop();
      vectors++;
      if (oe_cnt != oe_before || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mismatch_quiet got oe_cycles=%0d busy=%0b, want 0 and 0", oe_cnt - oe_before, busy);
      end
   endtask

   task automatic test_bank_select();
      logic ack;
      exp_q.push_back('{a: 8'hFF, d: 8'h01, b: 1'b1});
      bus_start();
      write_byte(8'h60, ack);
      write_byte(8'hFF, ack);
      write_byte(8'h01, ack);
      bus_stop();
      vectors++;
      if (bank !== 1'b1) begin
         miscompares++;
         $display("FAIL bank_set got %0b, want 1", bank);
      end
      exp_q.push_back('{a: 8'h0A, d: 8'h5C, b: 1'b1});
      bus_start();
      write_byte(8'h60, ack);
      write_byte(8'h0A, ack);
      write_byte(8'h5C, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("FAIL bank_data_ack got %0b, want 0", ack);
      end
      bus_stop();
      vectors++;
      if (bank !== 1'b1 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL bank_keep got bank=%0b pending=%0d, want 1 and 0", bank, exp_q.size());
      end
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] rb;
      bus_start();
      write_byte(8'h60, ack);
      write_byte(8'h0A, ack);
      bus_stop();
      bus_start();
      write_byte(8'h61, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("FAIL read_addr_ack got %0b, want 0", ack);
      end
      read_byte(rb, 1'b0);
      vectors++;
      if (rb !== 8'hA5) begin
         miscompares++;
         $display("FAIL read_byte0 got %02h, want a5", rb);
      end
      read_byte(rb, 1'b1);
      vectors++;
      if (rb !== 8'hA5) begin
         miscompares++;
         $display("FAIL read_byte1 got %02h, want a5", rb);
      end
      wait_clk(HALF);
      vectors++;
      if (sda_oe !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL read_release got oe=%0b busy=%0b, want 0 and 1", sda_oe, busy);
      end
      bus_stop();
      vectors++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL read_idle got busy=%0b pending=%0d, want 0 and 0", busy, exp_q.size());
      end
   endtask

   task automatic test_repeated_start();
      logic ack;
      bus_start();
      write_byte(8'h60, ack);
      send_bits(8'hE0, 3);
      exp_q.push_back('{a: 8'h20, d: 8'h33, b: 1'b1});
      bus_start();
      write_byte(8'h60, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("FAIL rstart_ack got %0b, want 0", ack);
      end
      write_byte(8'h20, ack);
      write_byte(8'h33, ack);
      bus_stop();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL rstart_pending got %0d, want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic ack;
      bit seen;
      exp_q.push_back('{a: 8'hFF, d: 8'h01, b: 1'b1});
      bus_start();
      write_byte(8'h60, ack);
      write_byte(8'hFF, ack);
      send_bits(8'h01, 8);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (sda_oe) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL ack_drive_timeout got oe=0 for 40 cycles, want 1");
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (sda_oe !== 1'b0 || bank !== 1'b0 || busy !== 1'b0 || reg_addr !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_abort got oe=%0b bank=%0b busy=%0b addr=%02h, want 0 0 0 00",
                  sda_oe, bank, busy, reg_addr);
      end
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(5);
      reset = 1'b0;
      wait_clk(10);
      exp_q.push_back('{a: 8'h33, d: 8'h44, b: 1'b0});
      bus_start();
      write_byte(8'h60, ack);
      write_byte(8'h33, ack);
      write_byte(8'h44, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_ack got %0b, want 0", ack);
      end
      bus_stop();
      vectors++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_done got pending=%0d busy=%0b, want 0 and 0", exp_q.size(), busy);
      end
   endtask

   initial begin
      fork
         scoreboard_mon();
      join_none
      test_reset();
      test_write_basic();
      test_addr_mismatch();
      test_bank_select();
      test_read();
      test_repeated_start();
      test_reset_mid();
      wait_clk(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog expired before end of test sequence");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C responder: the device-side end of the camera configuration bus.
- Oversamples SCL/SDA on the system clock, decodes 3-phase write and 2-phase read transactions, ACKs its device address, and drives the open-drain SDA low via sda_oe.
- Presents register writes and reads on a simple port to an external register file.
- Used as an FPGA-side camera stand-in and as the bus model in init-sequencer testbenches; tracks the 0xFF bank-select register internally.

Parameters:
- DEV_ADDR, 7'h30, 7-bit device address (write byte 0x60, read byte 0x61).
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (≥2).
- HOLD_CYCLES, 4, clk cycles after a detected SCL falling edge before sda_oe may change (data hold).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  bus SCL (async).
- sda_in  in  1  bus SDA (async).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- reg_addr  out  8  latched sub-address.
- reg_wdata  out  8  write data, valid with reg_wr.
- reg_wr  out  1  one-cycle write strobe.
- reg_rdata  in  8  read data for reg_addr/bank, sampled combinationally by this block.
- bank  out  1  bank select, bit0 of last write to 0xFF.
- busy  out  1  high from START to STOP.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr=0, bank=0, busy=0, FSM=IDLE.
- Reset mid-transaction aborts the transaction immediately and releases SDA.
- Sync: SYNC_STAGES flops per line, plus one extra flop for edge detect.
- SCL rise/fall and SDA rise/fall are one-cycle pulses computed on synchronized values.
- START = SDA fall while SCL high:
  - From any state, including mid-byte (repeated start), go to ADDR, clear bit count, busy=1.
- STOP = SDA rise while SCL high:
  - From any state, go to IDLE, sda_oe=0, busy=0.
  - No write strobe is generated for a partial byte.
- Bit sampling: on SCL rise, MSB first, 3-bit counter. Byte complete on the 8th rise.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift the address byte.
    - addr[7:1]==DEV_ADDR and R/W=0 -> ADDR_ACK then SUB.
    - Match and R/W=1 -> ADDR_ACK then RDATA.
    - Mismatch -> WAIT_STOP; SDA never driven.
  - SUB: shift the sub-address; latch into reg_addr at the 8th rise -> SUB_ACK -> WDATA.
  - WDATA: shift a data byte.
    - At the 8th rise: reg_wdata=byte; reg_wr=1 for exactly the next clk.
    - If reg_addr==8'hFF, bank=byte[0] in the same cycle.
    - Then WDATA_ACK -> EXTRA.
  - EXTRA: further bytes are shifted but not ACKed and not written; stay until STOP or START.
  - RDATA:
    - Load shifter from reg_rdata at entry, i.e. ADDR_ACK's 9th SCL falling edge.
    - Drive each bit HOLD_CYCLES after SCL fall: sda_oe = ~bit.
    - After 8 bits, release SDA -> RDATA_ACK.
  - RDATA_ACK: sample master SDA on the 9th rise.
    - 0 (ACK) -> reload the same register, repeat RDATA. No auto-increment.
    - 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: SDA released; ignore SCL until START or STOP.
- ACK timing:
  - sda_oe=1 asserted HOLD_CYCLES clk after the SCL fall that ends bit 8.
  - Held through the 9th SCL high; released HOLD_CYCLES after the 9th SCL fall.
- The HOLD counter restarts on every SCL fall.
- START/STOP detection while SCL is high overrides any pending hold counter.
- A read with no prior sub-address uses reg_addr from the last write phase (0 after reset).

Decomposition:
- Shared package sccb_pkg:
  - FSM state enum: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, EXTRA, RDATA, RDATA_ACK, WAIT_STOP.
  - Constants BANK_SEL_ADDR=8'hFF and SCCB_WRITE/SCCB_READ R/W bit values.
- One sub-module, sccb_line_sync: synchronizer plus edge/START/STOP pulse generation.

Test Plan:
- Write 0x60,0x12,0x80,STOP:
  - Three ACKs (SDA low during each 9th SCL high).
  - Single reg_wr pulse with reg_addr=0x12, reg_wdata=0x80; bank=0; busy low after STOP.
- Address 0x42 then 0x12,0x80:
  - sda_oe never asserts; no reg_wr; FSM in WAIT_STOP until STOP.
- Write 0x60,0xFF,0x01 then 0x60,0x0A,0x5C:
  - bank=1 after the first write.
  - Second write strobes addr 0x0A, data 0x5C, with bank still 1.
- Write 0x60,0x0A,STOP; then 0x61 with reg_rdata=0xA5:
  - SDA bits 1,0,1,0,0,1,0,1.
  - Master ACK -> 0xA5 repeated; master NACK -> SDA released; STOP -> idle.
- Repeated START after 3 bits of the sub-address, then a full write 0x60,0x20,0x33:
  - Partial byte discarded; one reg_wr (0x20,0x33).
- Assert reset while sda_oe=1 during a data ACK:
  - Next cycle sda_oe=0, bank=0, busy=0.
  - A following full write completes normally.
